// File: rtl/result_writeback_pkg.sv
// Shared types and defaults for the result write-back stage.
package result_writeback_pkg;

    localparam int unsigned DEF_ARRAY_SIZE   = 4;
    localparam int unsigned DEF_DATA_WIDTH   = 8;
    localparam int unsigned DEF_ACC_WIDTH    = 32;
    localparam int unsigned DEF_ADDR_WIDTH   = 8;
    localparam int unsigned DEF_BUFFER_WIDTH = DEF_ARRAY_SIZE * DEF_DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VALID,
        WRITE,
        DONE
    } wb_state_t;

    function automatic int unsigned shift_width(input int unsigned acc_width);
        return $clog2(acc_width);
    endfunction

endpackage

// File: rtl/result_writeback_if.sv
// Job control, result matrix and UB write-port signals of the write-back stage.
interface result_writeback_if
    import result_writeback_pkg::*;
#(
    parameter int unsigned N            = DEF_ARRAY_SIZE,
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned ACC_WIDTH    = DEF_ACC_WIDTH,
    parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int unsigned BUFFER_WIDTH = DEF_BUFFER_WIDTH,
    parameter int unsigned SHIFT_W      = shift_width(ACC_WIDTH)
);
    logic                          start;
    logic [ADDR_WIDTH-1:0]         base_addr;
    logic [SHIFT_W-1:0]            shift;
    logic                          relu_en;
    logic [N*N*ACC_WIDTH-1:0]      results_flat;
    logic                          result_valid;
    logic                          wr_grant;
    logic                          wr_en;
    logic [ADDR_WIDTH-1:0]         wr_addr;
    logic [BUFFER_WIDTH-1:0]       wr_data;
    logic                          busy;
    logic                          done;
    logic                          sat_flag;

    modport master (
        output start, base_addr, shift, relu_en, results_flat, result_valid, wr_grant,
        input  wr_en, wr_addr, wr_data, busy, done, sat_flag
    );

    modport slave (
        input  start, base_addr, shift, relu_en, results_flat, result_valid, wr_grant,
        output wr_en, wr_addr, wr_data, busy, done, sat_flag
    );
endinterface

// File: rtl/result_writeback_requant_unit.sv
// Combinational requantizer: rounded arithmetic shift, optional ReLU, signed saturation.
module requant_unit
    import result_writeback_pkg::*;
#(
    parameter int unsigned ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned SHIFT_W    = shift_width(ACC_WIDTH)
) (
    input  logic [ACC_WIDTH-1:0]  acc,
    input  logic [SHIFT_W-1:0]    shift,
    input  logic                  relu_en,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  sat
);
    localparam int unsigned EW = ACC_WIDTH + 1;
    localparam logic [SHIFT_W-1:0]   SMAX = SHIFT_W'(ACC_WIDTH - 1);
    localparam logic signed [EW-1:0] QMAX = EW'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [EW-1:0] QMIN = ~QMAX;

    logic [SHIFT_W-1:0]   s;
    logic signed [EW-1:0] ext;
    logic signed [EW-1:0] rnd;
    logic signed [EW-1:0] shifted;
    logic signed [EW-1:0] rect;
    logic signed [EW-1:0] clamped;

    always_comb begin
        s       = (shift > SMAX) ? SMAX : shift;
        ext     = $signed({acc[ACC_WIDTH-1], acc});
        rnd     = '0;
        shifted = ext;
        if (s != '0) begin
            rnd     = EW'(1) << (s - 1'b1);
            shifted = (ext + rnd) >>> s;
        end

        rect = shifted;
        if (relu_en && shifted[EW-1]) begin
            rect = '0;
        end

        sat     = 1'b0;
        clamped = rect;
        if (rect > QMAX) begin
            clamped = QMAX;
            sat     = 1'b1;
        end else if (rect < QMIN) begin
            clamped = QMIN;
            sat     = 1'b1;
        end
        q = clamped[DATA_WIDTH-1:0];
    end

endmodule

// File: rtl/result_writeback.sv
// Captures the N x N accumulator matrix, requantizes it and writes N packed rows to the UB.
module result_writeback
    import result_writeback_pkg::*;
#(
    parameter int unsigned N            = DEF_ARRAY_SIZE,
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned ACC_WIDTH    = DEF_ACC_WIDTH,
    parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int unsigned BUFFER_WIDTH = DEF_BUFFER_WIDTH,
    parameter int unsigned SHIFT_W      = shift_width(ACC_WIDTH)
) (
    input logic               clk,
    input logic               rst_n,
    result_writeback_if.slave bus
);
    localparam int unsigned ROW_W  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned BANK_W = N * N * DATA_WIDTH;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N - 1);

    if (BUFFER_WIDTH != N * DATA_WIDTH) begin : g_width_check
        $error("BUFFER_WIDTH must equal N*DATA_WIDTH");
    end

    wb_state_t               state_q, state_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic [ROW_W-1:0]        row_nx;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [SHIFT_W-1:0]      shift_q, shift_d;
    logic                    relu_q, relu_d;
    logic [BANK_W-1:0]       bank_q, bank_d;
    logic                    wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [BUFFER_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    sat_q, sat_d;

    logic [BANK_W-1:0]       quant_flat;
    logic [N*N-1:0]          sat_vec;

    // Requantizers see the latched job config, so they are stable across the capture cycle.
    for (genvar i = 0; i < N * N; i++) begin : g_rq
        requant_unit #(
            .ACC_WIDTH  (ACC_WIDTH),
            .DATA_WIDTH (DATA_WIDTH),
            .SHIFT_W    (SHIFT_W)
        ) u_rq (
            .acc     (bus.results_flat[i*ACC_WIDTH +: ACC_WIDTH]),
            .shift   (shift_q),
            .relu_en (relu_q),
            .q       (quant_flat[i*DATA_WIDTH +: DATA_WIDTH]),
            .sat     (sat_vec[i])
        );
    end

    assign row_nx = row_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        base_d    = base_q;
        shift_d   = shift_q;
        relu_d    = relu_q;
        bank_d    = bank_q;
        wr_en_d   = wr_en_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        sat_d     = sat_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    base_d  = bus.base_addr;
                    shift_d = bus.shift;
                    relu_d  = bus.relu_en;
                    sat_d   = 1'b0;
                    row_d   = '0;
                    busy_d  = 1'b1;
                    state_d = WAIT_VALID;
                end
            end
            WAIT_VALID: begin
                // Row 0 is loaded straight from the requantizers so the first write issues next cycle.
                if (bus.result_valid) begin
                    bank_d    = quant_flat;
                    sat_d     = sat_q | (|sat_vec);
                    wr_en_d   = 1'b1;
                    wr_addr_d = base_q;
                    wr_data_d = quant_flat[BUFFER_WIDTH-1:0];
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                if (bus.wr_grant) begin
                    if (row_q == LAST_ROW) begin
                        wr_en_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        row_d     = row_nx;
                        wr_addr_d = base_q + ADDR_WIDTH'(row_nx);
                        wr_data_d = bank_q[int'(row_nx) * BUFFER_WIDTH +: BUFFER_WIDTH];
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            row_q     <= '0;
            base_q    <= '0;
            shift_q   <= '0;
            relu_q    <= 1'b0;
            bank_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            base_q    <= base_d;
            shift_q   <= shift_d;
            relu_q    <= relu_d;
            bank_q    <= bank_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sat_q     <= sat_d;
        end
    end

    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.sat_flag = sat_q;

endmodule

// File: tb/tb_result_writeback.sv
// Scoreboard bench for result_writeback: random jobs against an arithmetic reference model.
module tb_result_writeback;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int AW  = 32;
    localparam int ADW = 8;
    localparam int BW  = N * DW;

    typedef struct packed {
        logic [ADW-1:0] addr;
        logic [BW-1:0]  data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    result_writeback_if #(
        .N            (N),
        .DATA_WIDTH   (DW),
        .ACC_WIDTH    (AW),
        .ADDR_WIDTH   (ADW),
        .BUFFER_WIDTH (BW)
    ) intf ();

    result_writeback #(
        .N            (N),
        .DATA_WIDTH   (DW),
        .ACC_WIDTH    (AW),
        .ADDR_WIDTH   (ADW),
        .BUFFER_WIDTH (BW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (intf.slave)
    );

    int  ncmp = 0;
    int  nfail = 0;
    wr_t exp_q[$];
    bit  exp_sat_q[$];
    int  pops = 0;
    int  stall_cnt = 0;
    int  done_cnt = 0;
    int  gmode = 0;
    int  stall_left = 0;
    logic [ADW-1:0] stall_addr = '0;
    int  mat[N*N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: floor((acc + 2^(s-1)) / 2^s), then ReLU, then clamp to int8.
    function automatic void model(input int acc, input int sh, input bit relu,
                                  output logic [DW-1:0] q, output bit sat);
        longint num, den, v;
        int s;
        s = (sh > AW - 1) ? AW - 1 : sh;
        if (s == 0) begin
            v = longint'(acc);
        end else begin
            num = longint'(acc) + (longint'(1) << (s - 1));
            den = longint'(1) << s;
            v = num / den;
            if ((num % den != 0) && (num < 0)) v = v - 1;
        end
        if (relu && v < 0) v = 0;
        sat = 1'b0;
        if (v > 127) begin v = 127; sat = 1'b1; end
        if (v < -128) begin v = -128; sat = 1'b1; end
        q = v[DW-1:0];
    endfunction

    function automatic logic [N*N*AW-1:0] pack_mat();
        logic [N*N*AW-1:0] f;
        for (int i = 0; i < N * N; i++) f[i*AW +: AW] = mat[i];
        return f;
    endfunction

    function automatic logic [N*N*AW-1:0] garbage();
        logic [N*N*AW-1:0] f;
        for (int i = 0; i < N * N; i++) f[i*AW +: AW] = $urandom;
        return f;
    endfunction

    function automatic int rnd_acc();
        case ($urandom_range(0, 3))
            0:       return int'($urandom);
            1:       return int'($urandom_range(0, 600)) - 300;
            default: return int'($urandom_range(0, 2000)) - 1000;
        endcase
    endfunction

    task automatic fill_small();
        for (int i = 0; i < N * N; i++) mat[i] = int'($urandom_range(0, 200)) - 100;
    endtask

    task automatic push_job(input logic [ADW-1:0] base, input int sh, input bit relu);
        bit any_sat;
        any_sat = 1'b0;
        for (int r = 0; r < N; r++) begin
            wr_t w;
            w.addr = base + ADW'(r);
            w.data = '0;
            for (int c = 0; c < N; c++) begin
                logic [DW-1:0] q;
                bit s;
                model(mat[r*N + c], sh, relu, q, s);
                w.data[c*DW +: DW] = q;
                any_sat |= s;
            end
            exp_q.push_back(w);
        end
        exp_sat_q.push_back(any_sat);
    endtask

    always @(posedge clk) begin
        #1;
        if (gmode == 2 && intf.wr_en && intf.wr_addr == stall_addr && stall_left > 0) begin
            intf.wr_grant = 1'b0;
            stall_left--;
        end else if (gmode == 1) begin
            intf.wr_grant = ($urandom_range(0, 2) != 0);
        end else begin
            intf.wr_grant = 1'b1;
        end
    end

    logic prev_stall = 1'b0;
    wr_t  prev_wr;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) chk("stall_hold", {intf.wr_en, intf.wr_addr, intf.wr_data}, {1'b1, prev_wr});
            prev_stall = intf.wr_en && !intf.wr_grant;
            prev_wr = {intf.wr_addr, intf.wr_data};
            if (prev_stall) stall_cnt++;
            if (intf.wr_en && intf.wr_grant) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", intf.wr_en, 0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("write", {intf.wr_addr, intf.wr_data}, e);
                    pops++;
                end
            end
            if (intf.done) begin
                done_cnt++;
                chk("busy_in_done", intf.busy, 1);
                if (exp_sat_q.size() == 0) chk("unexpected_done", intf.done, 0);
                else chk("sat_flag_at_done", intf.sat_flag, exp_sat_q.pop_front());
            end
        end
    end

    task automatic start_and_capture(input logic [ADW-1:0] base, input int sh, input bit relu, input int gm);
        gmode = gm;
        stall_left = 3;
        stall_addr = base + 1'b1;
        @(posedge clk); #1;
        intf.start = 1'b1;
        intf.base_addr = base;
        intf.shift = 5'(sh);
        intf.relu_en = relu;
        intf.results_flat = garbage();
        @(posedge clk); #1;
        intf.start = 1'b0;
        chk("busy_after_start", intf.busy, 1);
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        push_job(base, sh, relu);
        intf.results_flat = pack_mat();
        intf.result_valid = 1'b1;
        @(posedge clk); #1;
        intf.result_valid = 1'b0;
        intf.results_flat = garbage();
    endtask

    task automatic finish_job(input logic [ADW-1:0] base, input bit extra, input int exp_stalls);
        int lat, st0, dc0;
        st0 = stall_cnt;
        dc0 = done_cnt;
        lat = 0;
        while (lat < 200) begin
            @(posedge clk);
            lat++;
            if (extra) begin
                #1;
                if (lat == 1) begin
                    intf.start = 1'b1;
                    intf.base_addr = ~base;
                    intf.shift = '0;
                    intf.relu_en = ~intf.relu_en;
                    intf.result_valid = 1'b1;
                    intf.results_flat = garbage();
                end else begin
                    intf.start = 1'b0;
                    intf.result_valid = 1'b0;
                end
            end
            @(negedge clk);
            if (intf.done) break;
        end
        intf.start = 1'b0;
        intf.result_valid = 1'b0;
        chk("done_latency", lat, N + (stall_cnt - st0));
        if (exp_stalls >= 0) chk("stall_cycles", stall_cnt - st0, exp_stalls);
        @(posedge clk); #1;
        chk("idle_after_done", {intf.busy, intf.done, intf.wr_en}, 0);
        chk("done_pulses", done_cnt - dc0, 1);
        chk("writes_left", exp_q.size(), 0);
    endtask

    task automatic run_job(input logic [ADW-1:0] base, input int sh, input bit relu,
                           input int gm, input bit extra, input int exp_stalls);
        start_and_capture(base, sh, relu, gm);
        finish_job(base, extra, exp_stalls);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int p0;
        intf.start = 1'b0;
        intf.base_addr = '0;
        intf.shift = '0;
        intf.relu_en = 1'b0;
        intf.results_flat = '0;
        intf.result_valid = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {intf.wr_en, intf.wr_addr, intf.wr_data, intf.busy, intf.done, intf.sat_flag}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < N * N; i++) mat[i] = i;
        run_job(8'h10, 0, 1'b0, 0, 1'b0, 0);

        fill_small();
        mat[0] = 6; mat[1] = 5; mat[2] = -6; mat[3] = -7;
        run_job(8'h20, 2, 1'b0, 0, 1'b0, 0);

        fill_small();
        mat[5] = 300; mat[6] = -300;
        run_job(8'h30, 0, 1'b0, 0, 1'b0, 0);

        fill_small();
        mat[5] = -300; mat[9] = -300;
        run_job(8'h40, 0, 1'b1, 0, 1'b0, 0);

        fill_small();
        run_job(8'h50, 1, 1'b0, 2, 1'b0, 3);

        fill_small();
        run_job(8'h60, 0, 1'b0, 0, 1'b1, 0);

        p0 = pops;
        @(posedge clk); #1;
        intf.results_flat = garbage();
        intf.result_valid = 1'b1;
        @(posedge clk); #1;
        intf.result_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("idle_valid_busy", intf.busy, 0);
        chk("idle_valid_writes", pops - p0, 0);

        fill_small();
        run_job(8'hFE, 0, 1'b0, 0, 1'b0, 0);

        fill_small();
        mat[0] = 1000;
        p0 = pops;
        start_and_capture(8'h70, 0, 1'b0, 0);
        for (int k = 0; k < 50 && pops < p0 + 2; k++) @(negedge clk);
        chk("writes_before_reset", pops - p0, 2);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("reset_mid_write", {intf.wr_en, intf.wr_addr, intf.wr_data, intf.busy, intf.done, intf.sat_flag}, 0);
        exp_q.delete();
        exp_sat_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        fill_small();
        run_job(8'h80, 0, 1'b0, 0, 1'b0, 0);

        for (int j = 0; j < 12; j++) begin
            for (int i = 0; i < N * N; i++) mat[i] = rnd_acc();
            run_job(ADW'($urandom), int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1, 1'b0, -1);
        end

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
